// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 decrypt core: FSM states, the text
// character range and the supported read-latency bounds.
package rc4_pkg;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 4;
   localparam int unsigned RD_CNT_W   = $clog2(RD_LAT_MAX + 1);

   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_LO    = 8'h61;
   localparam logic [7:0] CHAR_HI    = 8'h7A;

   typedef enum logic [3:0] {
      IDLE,
      INC_I,
      RD_SI,
      RD_SJ,
      WR_SI,
      WR_SJ,
      RD_F,
      RD_E,
      WR_D,
      CHECK,
      DONE
   } rc4_state_e;

   // Lower-case letters or space count as plain text.
   function automatic logic is_text_char(input logic [7:0] b);
      return (b == CHAR_SPACE) || ((b >= CHAR_LO) && (b <= CHAR_HI));
   endfunction

endpackage

// File: rtl/rc4_rd_wait.sv
// Loadable down-counter timing the hold phase of every memory read; done
// pulses for one cycle RD_LAT cycles after load.
module rc4_rd_wait
   import rc4_pkg::*;
#(
   parameter int unsigned RD_LAT = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   output logic done
);

   localparam int unsigned LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                 (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

   logic [RD_CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (load) begin
         cnt  <= RD_CNT_W'(LAT);
         done <= 1'b0;
      end else begin
         done <= (cnt == RD_CNT_W'(1));
         if (cnt != '0) begin
            cnt <= cnt - RD_CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/rc4_decrypt_core.sv
// RC4 keystream generation and message decryption against external S-RAM,
// E-ROM and D-RAM. Define RC4_CHAR_CHECK_EN to abort on non-text output.
module rc4_decrypt_core
   import rc4_pkg::*;
#(
   parameter int unsigned MSG_LEN = 32,
   parameter int unsigned RD_LAT  = 2,
   parameter int unsigned MA_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [7:0]      s_q,
   input  logic [7:0]      e_q,
   output logic [7:0]      s_addr,
   output logic [7:0]      s_data,
   output logic            s_wren,
   output logic [MA_W-1:0] e_addr,
   output logic [MA_W-1:0] d_addr,
   output logic [7:0]      d_data,
   output logic            d_wren,
   output logic            busy,
   output logic            finish,
   output logic            valid
);

   localparam logic [MA_W-1:0] K_LAST = MA_W'(MSG_LEN - 1);

   rc4_state_e      state;
   logic [7:0]      i;
   logic [7:0]      j;
   logic [7:0]      si;
   logic [7:0]      sj;
   logic [7:0]      f;
   logic [MA_W-1:0] k;
   logic            rd_issue;
   logic            rd_done;
   logic            capture_c;

   rc4_rd_wait #(
      .RD_LAT (RD_LAT)
   ) u_rd_wait (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (rd_issue),
      .done    (rd_done)
   );

   // rd_issue marks the first cycle of a read state; done is only trusted after it.
   assign capture_c = !rd_issue && rd_done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         i        <= '0;
         j        <= '0;
         si       <= '0;
         sj       <= '0;
         f        <= '0;
         k        <= '0;
         rd_issue <= 1'b0;
         s_addr   <= '0;
         s_data   <= '0;
         s_wren   <= 1'b0;
         e_addr   <= '0;
         d_addr   <= '0;
         d_data   <= '0;
         d_wren   <= 1'b0;
         busy     <= 1'b0;
         finish   <= 1'b0;
         valid    <= 1'b0;
      end else begin
         rd_issue <= 1'b0;
         s_wren   <= 1'b0;
         d_wren   <= 1'b0;
         finish   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  i     <= '0;
                  j     <= '0;
                  k     <= '0;
                  valid <= 1'b1;
                  busy  <= 1'b1;
                  state <= INC_I;
               end
            end
            INC_I: begin
               i        <= i + 8'd1;
               s_addr   <= i + 8'd1;
               rd_issue <= 1'b1;
               state    <= RD_SI;
            end
            RD_SI: begin
               if (capture_c) begin
                  si       <= s_q;
                  j        <= j + s_q;
                  s_addr   <= j + s_q;
                  rd_issue <= 1'b1;
                  state    <= RD_SJ;
               end
            end
            RD_SJ: begin
               if (capture_c) begin
                  sj     <= s_q;
                  s_addr <= i;
                  s_data <= s_q;
                  s_wren <= 1'b1;
                  state  <= WR_SI;
               end
            end
            WR_SI: begin
               s_addr <= j;
               s_data <= si;
               s_wren <= 1'b1;
               state  <= WR_SJ;
            end
            // Keystream index comes from the latched pair, not from a re-read.
            WR_SJ: begin
               s_addr   <= si + sj;
               s_data   <= '0;
               rd_issue <= 1'b1;
               state    <= RD_F;
            end
            RD_F: begin
               if (capture_c) begin
                  f        <= s_q;
                  e_addr   <= k;
                  rd_issue <= 1'b1;
                  state    <= RD_E;
               end
            end
            RD_E: begin
               if (capture_c) begin
                  d_addr <= k;
                  d_data <= f ^ e_q;
                  d_wren <= 1'b1;
                  state  <= WR_D;
               end
            end
            WR_D: begin
               state <= CHECK;
            end
            CHECK: begin
`ifdef RC4_CHAR_CHECK_EN
               if (!is_text_char(d_data)) begin
                  valid  <= 1'b0;
                  finish <= 1'b1;
                  state  <= DONE;
               end else if (k == K_LAST) begin
                  finish <= 1'b1;
                  state  <= DONE;
               end else begin
                  k     <= k + MA_W'(1);
                  state <= INC_I;
               end
`else
               if (k == K_LAST) begin
                  finish <= 1'b1;
                  state  <= DONE;
               end else begin
                  k     <= k + MA_W'(1);
                  state <= INC_I;
               end
`endif
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Directed bench for rc4_decrypt_core: three instances (RD_LAT 2/1/4) with
// latency-matched S-RAM, E-ROM and D-RAM models.
module tb_rc4_decrypt_core;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic [2:0]        start_v = '0;
   logic [2:0]        init_req = '0;
   logic [7:0]        e_img [256];
   wire  [2:0]        busy_v;
   wire  [2:0]        finish_v;
   wire  [2:0]        valid_v;
   wire  [2:0]        out_nz_v;
   int unsigned       cyc_now = 0;
   int                checks = 0;
   int                failures = 0;

   logic [7:0] exp_id [8] = '{8'h02, 8'h05, 8'h07, 8'h0D, 8'h0D, 8'h17, 8'h1F, 8'h28};

   always #5 clk = ~clk;
   always @(posedge clk) cyc_now <= cyc_now + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      localparam int unsigned LEN = (g == 0) ? 4 : 8;
      localparam int unsigned AW  = (LEN > 1) ? $clog2(LEN) : 1;

      logic [7:0]    s_q, e_q, s_addr, s_data, d_data;
      logic          s_wren, d_wren, busy, finish, valid;
      logic [AW-1:0] e_addr, d_addr;
      logic [7:0]    s_mem [256];
      logic [7:0]    e_mem [256];
      logic [7:0]    d_mem [256];
      logic [7:0]    s_pipe [LAT];
      logic [7:0]    e_pipe [LAT];
      int            d_cnt;
      int            mutex_err;
      int unsigned   d_time [256];

      rc4_decrypt_core #(.MSG_LEN(LEN), .RD_LAT(LAT)) u_dut (
         .clk     (clk),
         .reset_n (reset_n),
         .start   (start_v[g]),
         .s_q     (s_q),
         .e_q     (e_q),
         .s_addr  (s_addr),
         .s_data  (s_data),
         .s_wren  (s_wren),
         .e_addr  (e_addr),
         .d_addr  (d_addr),
         .d_data  (d_data),
         .d_wren  (d_wren),
         .busy    (busy),
         .finish  (finish),
         .valid   (valid)
      );

      assign s_q = s_pipe[LAT-1];
      assign e_q = e_pipe[LAT-1];

      always @(posedge clk) begin
         if (init_req[g]) begin
            for (int a = 0; a < 256; a++) begin
               s_mem[a] <= 8'(a);
               e_mem[a] <= e_img[a];
               d_mem[a] <= 8'h00;
            end
            d_cnt     <= 0;
            mutex_err <= 0;
         end else begin
            s_pipe[0] <= s_mem[s_addr];
            e_pipe[0] <= e_mem[e_addr];
            for (int p = 1; p < LAT; p++) begin
               s_pipe[p] <= s_pipe[p-1];
               e_pipe[p] <= e_pipe[p-1];
            end
            if (s_wren) s_mem[s_addr] <= s_data;
            if (d_wren) begin
               d_mem[d_addr]  <= d_data;
               d_time[d_cnt]  <= cyc_now;
               d_cnt          <= d_cnt + 1;
            end
            if (s_wren && d_wren) mutex_err <= mutex_err + 1;
         end
      end

      assign busy_v[g]   = busy;
      assign finish_v[g] = finish;
      assign valid_v[g]  = valid;
      assign out_nz_v[g] = |{s_addr, s_data, s_wren, e_addr, d_addr, d_data,
                             d_wren, busy, finish, valid};
   end

   task automatic set_e(input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [7:0] e3);
      for (int a = 0; a < 256; a++) e_img[a] = 8'h00;
      e_img[0] = e0; e_img[1] = e1; e_img[2] = e2; e_img[3] = e3;
   endtask

   task automatic do_init(input int g);
      @(negedge clk);
      init_req[g] = 1'b1;
      @(negedge clk);
      init_req[g] = 1'b0;
   endtask

   // Pulse start for one edge, then count edges until finish (bounded).
   task automatic start_and_wait(input int g, input int budget, output int cyc);
      @(negedge clk);
      start_v[g] = 1'b1;
      @(posedge clk);
      #1;
      start_v[g] = 1'b0;
      cyc = 0;
      while (finish_v[g] !== 1'b1 && cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic test_reset;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (out_nz_v !== 3'b000) begin
         failures++;
         $display("FAIL reset_outputs nonzero_mask=%b exp=000", out_nz_v);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_basic;
      int cyc;
      set_e(8'h00, 8'h00, 8'h00, 8'h00);
      do_init(0);
      start_and_wait(0, 500, cyc);
      checks++;
      if (cyc !== 84) begin failures++; $display("FAIL basic_latency got=%0d exp=84", cyc); end
      checks++;
      if (valid_v[0] !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", valid_v[0]); end
      checks++;
      if (g_dut[0].d_cnt !== 4) begin failures++; $display("FAIL basic_dwren_count got=%0d exp=4", g_dut[0].d_cnt); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (g_dut[0].d_mem[k] !== exp_id[k]) begin
            failures++;
            $display("FAIL basic_d%0d got=%h exp=%h", k, g_dut[0].d_mem[k], exp_id[k]);
         end
      end
      checks++;
      if (g_dut[0].s_mem[2] !== 8'h03) begin failures++; $display("FAIL basic_s2 got=%h exp=03", g_dut[0].s_mem[2]); end
      checks++;
      if (g_dut[0].s_mem[3] !== 8'h05) begin failures++; $display("FAIL basic_s3 got=%h exp=05", g_dut[0].s_mem[3]); end
      checks++;
      if (g_dut[0].s_mem[5] !== 8'h02) begin failures++; $display("FAIL basic_s5 got=%h exp=02", g_dut[0].s_mem[5]); end
      checks++;
      if (g_dut[0].d_time[1] - g_dut[0].d_time[0] !== 21) begin
         failures++;
         $display("FAIL basic_byte_latency got=%0d exp=21", g_dut[0].d_time[1] - g_dut[0].d_time[0]);
      end
      checks++;
      if (g_dut[0].mutex_err !== 0) begin failures++; $display("FAIL basic_wren_overlap got=%0d exp=0", g_dut[0].mutex_err); end
      @(posedge clk);
      #1;
      checks++;
      if (finish_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
         failures++;
         $display("FAIL basic_after_done finish=%b busy=%b exp=0/0", finish_v[0], busy_v[0]);
      end
      checks++;
      if (valid_v[0] !== 1'b1) begin failures++; $display("FAIL basic_valid_hold got=%b exp=1", valid_v[0]); end
   endtask

   task automatic test_rd_lat;
      int cyc;
      set_e(8'h00, 8'h00, 8'h00, 8'h00);
      do_init(1);
      start_and_wait(1, 1000, cyc);
      checks++;
      if (cyc !== 136) begin failures++; $display("FAIL lat1_latency got=%0d exp=136", cyc); end
      checks++;
      if (g_dut[1].d_time[1] - g_dut[1].d_time[0] !== 17) begin
         failures++;
         $display("FAIL lat1_byte_latency got=%0d exp=17", g_dut[1].d_time[1] - g_dut[1].d_time[0]);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (g_dut[1].d_mem[k] !== exp_id[k]) begin
            failures++;
            $display("FAIL lat1_d%0d got=%h exp=%h", k, g_dut[1].d_mem[k], exp_id[k]);
         end
      end
      do_init(2);
      start_and_wait(2, 1000, cyc);
      checks++;
      if (cyc !== 232) begin failures++; $display("FAIL lat4_latency got=%0d exp=232", cyc); end
      checks++;
      if (g_dut[2].d_time[1] - g_dut[2].d_time[0] !== 29) begin
         failures++;
         $display("FAIL lat4_byte_latency got=%0d exp=29", g_dut[2].d_time[1] - g_dut[2].d_time[0]);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (g_dut[2].d_mem[k] !== exp_id[k]) begin
            failures++;
            $display("FAIL lat4_d%0d got=%h exp=%h", k, g_dut[2].d_mem[k], exp_id[k]);
         end
      end
   endtask

   task automatic test_char_check;
      int cyc;
      logic [7:0] exp_txt [4];
`ifdef RC4_CHAR_CHECK_EN
      exp_txt = '{8'h61, 8'h62, 8'h20, 8'h63};
      set_e(8'h63, 8'h67, 8'h27, 8'h6E);
      do_init(0);
      start_and_wait(0, 500, cyc);
      checks++;
      if (g_dut[0].d_cnt !== 4 || valid_v[0] !== 1'b1) begin
         failures++;
         $display("FAIL text_pass count=%0d valid=%b exp=4/1", g_dut[0].d_cnt, valid_v[0]);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (g_dut[0].d_mem[k] !== exp_txt[k]) begin
            failures++;
            $display("FAIL text_pass_d%0d got=%h exp=%h", k, g_dut[0].d_mem[k], exp_txt[k]);
         end
      end
      set_e(8'h63, 8'h67, 8'h46, 8'h6E);
      do_init(0);
      start_and_wait(0, 500, cyc);
      checks++;
      if (cyc !== 63) begin failures++; $display("FAIL text_abort_latency got=%0d exp=63", cyc); end
      checks++;
      if (g_dut[0].d_cnt !== 3 || valid_v[0] !== 1'b0) begin
         failures++;
         $display("FAIL text_abort count=%0d valid=%b exp=3/0", g_dut[0].d_cnt, valid_v[0]);
      end
      checks++;
      if (g_dut[0].d_mem[2] !== 8'h41 || g_dut[0].d_mem[3] !== 8'h00) begin
         failures++;
         $display("FAIL text_abort_data d2=%h d3=%h exp=41/00", g_dut[0].d_mem[2], g_dut[0].d_mem[3]);
      end
`else
      exp_txt = '{8'h61, 8'h62, 8'h41, 8'h63};
      set_e(8'h63, 8'h67, 8'h46, 8'h6E);
      do_init(0);
      start_and_wait(0, 500, cyc);
      checks++;
      if (cyc !== 84) begin failures++; $display("FAIL nocheck_latency got=%0d exp=84", cyc); end
      checks++;
      if (g_dut[0].d_cnt !== 4 || valid_v[0] !== 1'b1) begin
         failures++;
         $display("FAIL nocheck_status count=%0d valid=%b exp=4/1", g_dut[0].d_cnt, valid_v[0]);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (g_dut[0].d_mem[k] !== exp_txt[k]) begin
            failures++;
            $display("FAIL nocheck_d%0d got=%h exp=%h", k, g_dut[0].d_mem[k], exp_txt[k]);
         end
      end
`endif
   endtask

   task automatic test_back_to_back;
      int cyc;
      set_e(8'h00, 8'h00, 8'h00, 8'h00);
      do_init(0);
      @(negedge clk);
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      cyc = 0;
      while (finish_v[0] !== 1'b1 && cyc < 500) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checks++;
      if (cyc !== 84) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=84", cyc); end
      @(posedge clk);
      #1;
      checks++;
      if (busy_v[0] !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap busy=%b exp=0", busy_v[0]); end
      @(posedge clk);
      #1;
      checks++;
      if (busy_v[0] !== 1'b1 || valid_v[0] !== 1'b1) begin
         failures++;
         $display("FAIL b2b_restart busy=%b valid=%b exp=1/1", busy_v[0], valid_v[0]);
      end
      start_v[0] = 1'b0;
      cyc = 0;
      while (finish_v[0] !== 1'b1 && cyc < 500) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checks++;
      if (cyc !== 84) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=84", cyc); end
   endtask

   task automatic test_reset_mid;
      int n;
      int t;
      int cyc;
      set_e(8'h00, 8'h00, 8'h00, 8'h00);
      do_init(1);
      @(negedge clk);
      start_v[1] = 1'b1;
      @(posedge clk);
      #1;
      start_v[1] = 1'b0;
      n = 0;
      t = 0;
      while (n < 11 && t < 2000) begin
         @(negedge clk);
         t++;
         if (g_dut[1].s_wren === 1'b1) n++;
      end
      checks++;
      if (n !== 11) begin failures++; $display("FAIL midreset_reach_wr_si got=%0d exp=11", n); end
      checks++;
      if (g_dut[1].s_addr !== 8'h06 || g_dut[1].s_data !== 8'h11) begin
         failures++;
         $display("FAIL midreset_wr_si addr=%h data=%h exp=06/11", g_dut[1].s_addr, g_dut[1].s_data);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (out_nz_v !== 3'b000) begin failures++; $display("FAIL midreset_outputs nonzero_mask=%b exp=000", out_nz_v); end
      checks++;
      if (g_dut[1].d_cnt !== 5) begin failures++; $display("FAIL midreset_dwren_count got=%0d exp=5", g_dut[1].d_cnt); end
      repeat (2) @(negedge clk);
      init_req[1] = 1'b1;
      @(negedge clk);
      init_req[1] = 1'b0;
      start_v[1]  = 1'b1;
      reset_n     = 1'b1;
      @(posedge clk);
      #1;
      start_v[1] = 1'b0;
      checks++;
      if (busy_v[1] !== 1'b1) begin failures++; $display("FAIL midreset_first_start busy=%b exp=1", busy_v[1]); end
      cyc = 0;
      while (finish_v[1] !== 1'b1 && cyc < 1000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checks++;
      if (cyc !== 136 || valid_v[1] !== 1'b1) begin
         failures++;
         $display("FAIL midreset_rerun latency=%0d valid=%b exp=136/1", cyc, valid_v[1]);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (g_dut[1].d_mem[k] !== exp_id[k]) begin
            failures++;
            $display("FAIL midreset_rerun_d%0d got=%h exp=%h", k, g_dut[1].d_mem[k], exp_id[k]);
         end
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) e_img[a] = 8'h00;
      test_reset();
      test_basic();
      test_rd_lat();
      test_char_check();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
